// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage.
// Holds the PC, issues word reads to a synchronous-read instruction BRAM,
// latches the returned word into the instruction register and resolves the
// next PC from the decoder's branch/jump flags. There are three cycles per
// instruction (FETCH, WAIT, EXEC). EXEC may be stretched by stall, and any
// fetch fault parks the unit in HALT until reset.
//
// Optional build macro: IFETCH_PERF_EN adds the retired_cnt output, a
// retired-instruction counter.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   stall                           hold the current instruction in EXEC
//   Branch..branch_geu, jal, jalr   decoder control flags
//   rs1_data, rs2_data, imm32       operands for target/compare
//   imem_en, imem_addr, imem_rdata  instruction BRAM read port
//   instruction, instr_valid        instruction register and its valid flag
//   pc, pc_plus4                    current PC and link value (pc_plus4 comb)
//   trap, trap_cause                sticky fault flag: 01 misaligned, 10 range
//   retired_cnt                     (IFETCH_PERF_EN only) retired count

module ifetch_unit #(
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter int unsigned IMEM_ADDR_W = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   Branch,
    input  logic                   nBranch,
    input  logic                   branch_lt,
    input  logic                   branch_ge,
    input  logic                   branch_ltu,
    input  logic                   branch_geu,
    input  logic                   jal,
    input  logic                   jalr,
    input  logic [31:0]            rs1_data,
    input  logic [31:0]            rs2_data,
    input  logic [31:0]            imm32,
    output logic                   imem_en,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [31:0]            imem_rdata,
    output logic [31:0]            instruction,
    output logic                   instr_valid,
    output logic [31:0]            pc,
    output logic [31:0]            pc_plus4,
    output logic                   trap,
    output logic [1:0]             trap_cause
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]            retired_cnt
`endif
);

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int unsigned RANGE_SHIFT = IMEM_ADDR_W + 2;
    localparam logic [1:0]  CAUSE_MISAL = 2'b01;
    localparam logic [1:0]  CAUSE_RANGE = 2'b10;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        en_q, en_d;
    logic        trap_q, trap_d;
    logic [1:0]  cause_q, cause_d;
    logic        retire_c;

    logic        eq_c, slt_c, ult_c, taken_c;
    logic [31:0] jalr_tgt_c, next_pc_c;
    logic        pc_oor_c, next_oor_c;

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign imem_addr   = pc_q[RANGE_SHIFT-1:2];
    assign imem_en     = en_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign trap        = trap_q;
    assign trap_cause  = cause_q;

    // Operand compares shared by all conditional branch flavours
    assign eq_c  = (rs1_data == rs2_data);
    assign slt_c = ($signed(rs1_data) < $signed(rs2_data));
    assign ult_c = (rs1_data < rs2_data);

    // Branch decision; when several flags are set the first one listed wins
    always_comb begin
        taken_c = 1'b0;
        if (Branch)          taken_c = eq_c;
        else if (nBranch)    taken_c = !eq_c;
        else if (branch_lt)  taken_c = slt_c;
        else if (branch_ge)  taken_c = !slt_c;
        else if (branch_ltu) taken_c = ult_c;
        else if (branch_geu) taken_c = !ult_c;
    end

    // Next-PC resolution: jalr > jal > taken branch > sequential
    assign jalr_tgt_c = (rs1_data + imm32) & ~32'h1;
    always_comb begin
        if (jalr)                next_pc_c = jalr_tgt_c;
        else if (jal || taken_c) next_pc_c = pc_q + imm32;
        else                     next_pc_c = pc_q + 32'd4;
    end

    // A PC is out of range when any bit above the BRAM byte span is set
    assign pc_oor_c   = |(pc_q >> RANGE_SHIFT);
    assign next_oor_c = |(next_pc_c >> RANGE_SHIFT);

    // Fetch FSM next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        en_d     = en_q;
        trap_d   = trap_q;
        cause_d  = cause_q;
        retire_c = 1'b0;

        case (state_q)
            S_FETCH: begin
                valid_d = 1'b0;
                if (pc_oor_c) begin
                    en_d    = 1'b0;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_RANGE;
                    state_d = S_HALT;
                end else if (!en_q) begin
                    // Only after reset: the read enable is not up yet, so
                    // spend one cycle raising it before waiting on data.
                    en_d = 1'b1;
                end else begin
                    en_d    = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                en_d    = 1'b0;
                instr_d = imem_rdata;
                valid_d = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!stall) begin
                    valid_d = 1'b0;
                    if (next_pc_c[1:0] != 2'b00) begin
                        trap_d  = 1'b1;
                        cause_d = CAUSE_MISAL;
                        state_d = S_HALT;
                    end else begin
                        pc_d     = next_pc_c;
                        // Pre-arm the read so FETCH issues it immediately;
                        // an out-of-range target leaves it off and traps there.
                        en_d     = !next_oor_c;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                en_d    = 1'b0;
                valid_d = 1'b0;
            end
            default: begin
                en_d    = 1'b0;
                valid_d = 1'b0;
                state_d = S_HALT;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RESET;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            en_q    <= 1'b0;
            trap_q  <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            en_q    <= en_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

`ifdef IFETCH_PERF_EN
    // Retired-instruction counter, wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= 32'd0;
        end else if (retire_c) begin
            retired_cnt <= retired_cnt + 32'd1;
        end
    end
`else
    logic unused_retire;
    assign unused_retire = retire_c;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

    localparam int unsigned AW    = 8;
    localparam logic [31:0] LIMIT = 32'h0000_0400;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic [7:0]    flg = 8'h00;   // {jalr, jal, Branch, nBranch, lt, ge, ltu, geu}
    logic [31:0]   rs1 = 32'h0, rs2 = 32'h0, imm = 32'h0;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata = 32'h0;
    logic [31:0]   instruction, pc, pc_plus4;
    logic          instr_valid, trap;
    logic [1:0]    trap_cause;
`ifdef IFETCH_PERF_EN
    logic [31:0]   retired_cnt;
`endif

    logic [31:0] mem [256];
    logic [31:0] ref_pc;
    logic [31:0] ref_ret;
    int tests = 0;
    int fails = 0;

    ifetch_unit #(.PC_RESET(32'h0), .IMEM_ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .Branch(flg[5]), .nBranch(flg[4]), .branch_lt(flg[3]), .branch_ge(flg[2]),
        .branch_ltu(flg[1]), .branch_geu(flg[0]), .jal(flg[6]), .jalr(flg[7]),
        .rs1_data(rs1), .rs2_data(rs2), .imm32(imm),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instruction(instruction), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4), .trap(trap), .trap_cause(trap_cause)
`ifdef IFETCH_PERF_EN
        , .retired_cnt(retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory
    always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Next PC straight from the architectural rules
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [7:0] f,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] i);
        bit t;
        if (f[7]) return (a + i) & 32'hFFFF_FFFE;
        if (f[6]) return p + i;
        if (f[5])      t = (a == b);
        else if (f[4]) t = (a != b);
        else if (f[3]) t = ($signed(a) < $signed(b));
        else if (f[2]) t = ($signed(a) >= $signed(b));
        else if (f[1]) t = (a < b);
        else if (f[0]) t = (a >= b);
        else           t = 1'b0;
        return t ? p + i : p + 32'd4;
    endfunction

    // Reset from anywhere; ends at the negedge where FETCH has its read enabled
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instruction, NOP);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_en", 32'(imem_en), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_cause", 32'(trap_cause), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        ref_pc = 32'h0;
        ref_ret = 32'h0;
        chk("cyc0_en", 32'(imem_en), 32'd0);
        chk("cyc0_pc", pc, 32'h0);
`ifdef IFETCH_PERF_EN
        chk("rst_retired", retired_cnt, 32'd0);
`endif
        @(negedge clk);
    endtask

    // One instruction from its FETCH cycle through EXEC exit
    task automatic exec_instr(input int nstall, input logic [7:0] f, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] i,
                              output bit halted, output logic [1:0] hcause);
        logic [31:0] npc;
        halted = 1'b0;
        hcause = 2'b00;
        chk("fetch_en", 32'(imem_en), 32'd1);
        chk("fetch_addr", 32'(imem_addr), 32'(ref_pc[AW+1:2]));
        chk("fetch_pc", pc, ref_pc);
        chk("pc_plus4", pc_plus4, ref_pc + 32'd4);
        chk("fetch_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("wait_en", 32'(imem_en), 32'd0);
        chk("wait_valid", 32'(instr_valid), 32'd0);
        chk("wait_pc", pc, ref_pc);
        @(negedge clk);
        chk("exec_valid", 32'(instr_valid), 32'd1);
        chk("exec_instr", instruction, mem[ref_pc[AW+1:2]]);
        chk("exec_pc", pc, ref_pc);
        for (int k = 0; k < nstall; k++) begin
            stall = 1'b1;
            flg = 8'($urandom);
            rs1 = $urandom;
            @(negedge clk);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_pc", pc, ref_pc);
            chk("stall_instr", instruction, mem[ref_pc[AW+1:2]]);
        end
        stall = 1'b0;
        flg = f; rs1 = a; rs2 = b; imm = i;
        npc = ref_next(ref_pc, f, a, b, i);
        @(negedge clk);
        flg = 8'($urandom);
        stall = 1'($urandom_range(0, 1));
        if (npc[1:0] != 2'b00) begin
            chk("misal_trap", 32'(trap), 32'd1);
            chk("misal_cause", 32'(trap_cause), 32'd1);
            chk("misal_pc", pc, ref_pc);
            chk("misal_valid", 32'(instr_valid), 32'd0);
            chk("misal_en", 32'(imem_en), 32'd0);
            halted = 1'b1;
            hcause = 2'b01;
        end else begin
            ref_pc = npc;
            ref_ret = ref_ret + 32'd1;
            if (npc >= LIMIT) begin
                chk("oor_fetch_en", 32'(imem_en), 32'd0);
                chk("oor_fetch_trap", 32'(trap), 32'd0);
                chk("oor_fetch_pc", pc, npc);
                @(negedge clk);
                chk("oor_trap", 32'(trap), 32'd1);
                chk("oor_cause", 32'(trap_cause), 32'd2);
                chk("oor_en", 32'(imem_en), 32'd0);
                halted = 1'b1;
                hcause = 2'b10;
            end
        end
`ifdef IFETCH_PERF_EN
        chk("retired", retired_cnt, ref_ret);
`endif
    endtask

    task automatic check_frozen(input logic [1:0] cause);
        for (int k = 0; k < 3; k++) begin
            stall = 1'($urandom_range(0, 1));
            flg = 8'($urandom);
            @(negedge clk);
            chk("halt_trap", 32'(trap), 32'd1);
            chk("halt_cause", 32'(trap_cause), 32'(cause));
            chk("halt_pc", pc, ref_pc);
            chk("halt_valid", 32'(instr_valid), 32'd0);
            chk("halt_en", 32'(imem_en), 32'd0);
        end
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit h;
        logic [1:0] c;
        logic [7:0] f;
        logic [31:0] a, b, i;
        int s;

        for (int k = 0; k < 256; k++) mem[k] = $urandom;
        mem[0] = 32'h0050_0093;
        @(negedge clk);
        do_reset();

        // Sequential run, then conditional branches and jumps
        exec_instr(0, 8'h00, 32'h0, 32'h0, 32'h0, h, c);
        exec_instr(0, 8'h00, 32'h0, 32'h0, 32'h0, h, c);
        exec_instr(0, 8'h00, 32'h0, 32'h0, 32'h0, h, c);
        exec_instr(0, 8'h00, 32'h0, 32'h0, 32'h0, h, c);
        exec_instr(0, 8'h20, 32'd5, 32'd5, 32'hFFFF_FFF8, h, c);   // beq @0x10 -> 0x08
        exec_instr(0, 8'h00, 32'h0, 32'h0, 32'h0, h, c);
        exec_instr(0, 8'h00, 32'h0, 32'h0, 32'h0, h, c);
        exec_instr(0, 8'h10, 32'd5, 32'd5, 32'hFFFF_FFF8, h, c);   // bne @0x10 -> 0x14
        exec_instr(0, 8'h40, 32'h0, 32'h0, 32'h0000_000C, h, c);   // jal -> 0x20
        exec_instr(0, 8'h08, 32'hFFFF_FFFF, 32'd1, 32'd16, h, c);  // blt -> 0x30
        exec_instr(0, 8'h40, 32'h0, 32'h0, 32'hFFFF_FFF0, h, c);   // jal -> 0x20
        exec_instr(0, 8'h02, 32'hFFFF_FFFF, 32'd1, 32'd16, h, c);  // bltu -> 0x24
        exec_instr(0, 8'h28, 32'd3, 32'd4, 32'd16, h, c);          // beq wins over blt
        exec_instr(5, 8'h80, 32'h0000_0101, 32'h0, 32'd2, h, c);   // jalr -> 0x102
        chk("directed_halt", 32'(h), 32'd1);
        check_frozen(2'b01);

        // Reset landing in the middle of WAIT
        do_reset();
        @(negedge clk);
        do_reset();
        exec_instr(0, 8'h00, 32'h0, 32'h0, 32'h0, h, c);

        // Jump just past the end of instruction memory
        exec_instr(1, 8'h80, 32'h0000_03FC, 32'h0, 32'd4, h, c);
        chk("oor_halt", 32'(h), 32'd1);
        check_frozen(2'b10);
        do_reset();

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            s = $urandom_range(0, 9);
            if (s < 8)       f = 8'(1 << s);
            else if (s == 8) f = 8'h00;
            else             f = 8'($urandom);
            a = rnd_op();
            b = ($urandom_range(0, 2) == 0) ? a : rnd_op();
            s = int'($urandom_range(0, 32)) - 16;
            i = 32'(s * 4);
            if ($urandom_range(0, 9) == 0) i = i + 32'd2;
            if (f[7]) a = 32'($urandom_range(0, 255) * 4 + $urandom_range(0, 1));
            exec_instr(int'($urandom_range(0, 2)), f, a, b, i, h, c);
            if (h) begin
                check_frozen(c);
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
